ps2_packet_framer: RTL and testbench
====================================

# ps2_packet_framer

Parametrised PS/2-style packet framer that assembles fixed-length multi-byte packets from a strobed byte stream. The first byte of a packet is recognised by a sync bit. The block is the generalised successor of the fixed 3-byte mouse-packet detector and sits between the PS/2 byte receiver and the host-side event decoder. Over that detector it adds:
- a byte-valid strobe
- configurable packet length and sync position
- an inter-byte timeout with error pulse
- a held, always-valid output
- a saturating discard counter

## Interface
- BYTE_W, 8, bits per received byte
- PKT_BYTES, 3, bytes per packet (≥2)
- SYNC_BIT, 3, bit index in the first byte that must be 1 (< BYTE_W)
- TIMEOUT_CYC, 1000, max idle cycles between bytes of one packet; 0 disables the timeout
- DROP_W, 8, width of the discard counter
---
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_byte  in  BYTE_W  received byte
- in_valid  in  1  in_byte is valid this cycle (one byte per asserted cycle)
- out_bytes  out  PKT_BYTES*BYTE_W  last complete packet; first byte in MSBs
- done  out  1  one-cycle pulse: out_bytes just updated with a new packet
- err  out  1  one-cycle pulse: packet aborted by timeout
- drop_cnt  out  DROP_W  saturating count of bytes discarded while hunting for sync

## Operation
- States (shared enum): HUNT, COLLECT.
- HUNT, in_valid=1, in_byte[SYNC_BIT]=1: store the byte as byte 0, set idx=1, clear the gap counter, go to COLLECT.
- HUNT, in_valid=1, sync bit 0: discard the byte; drop_cnt += 1, saturating at 2^DROP_W−1.
- HUNT, in_valid=0: no change.
- COLLECT, in_valid=1: store the byte at position idx and clear the gap counter.
  - If idx == PKT_BYTES−1: load out_bytes with the full packet, pulse done, go to HUNT.
  - Otherwise idx += 1.
- COLLECT, in_valid=0: gap counter += 1. When the counter reaches TIMEOUT_CYC (TIMEOUT_CYC ≠ 0): pulse err, discard the partial packet, go to HUNT.
- The sync bit is checked only on byte 0. Later bytes are accepted whatever their value.
- out_bytes changes only on packet completion and holds its value otherwise. It is never X.
- A partial packet never modifies out_bytes.
- drop_cnt is not incremented for bytes accepted into a packet, nor on timeout.

## Timing
- Reset values: state HUNT, idx 0, gap counter 0, out_bytes 0, done 0, err 0, drop_cnt 0.
- Reset applies immediately and asynchronously, mid-packet included. Partial data is lost and no done/err is issued.
- Latency: the last byte is sampled at edge k. out_bytes and done are both updated at edge k, so done is high for the cycle between edges k and k+1.
- Back-to-back packets: the state is HUNT right after the completion edge. A sync byte on the very next valid cycle starts the next packet with zero lost bytes.
- Minimum packet period is PKT_BYTES cycles.
- Timeout boundary: after edge k+TIMEOUT_CYC with no valid byte since the byte at edge k, state is HUNT and err is high for one cycle.
- If in_valid=1 on the same cycle the counter would reach the limit, the byte wins: it is accepted and there is no err.
- done and err are never high in the same cycle.
- The gap counter width is $clog2(TIMEOUT_CYC+1), minimum 1. The counter does not run in HUNT.

## Structure
- Package ps2_pkg holds:
  - the state enum typedef {HUNT, COLLECT}
  - default parameter constants (BYTE_W, PKT_BYTES, SYNC_BIT)
  - helper function pkt_w(n, w) = n*w
- Sub-module ps2_gap_timer, a parametrised TIMEOUT_CYC counter.
  - Inputs: clk, reset, run, clr.
  - Output: expired, pulsed once when the count reaches the limit.
  - Tied off when TIMEOUT_CYC=0.
- The top holds the FSM, index counter, shift/assembly register, output register and drop counter.

## Test plan
- Defaults, valid bytes 0x08,0x12,0x34 on consecutive cycles:
  - done pulses once, in the cycle after the 3rd byte.
  - out_bytes=0x081234.
  - drop_cnt=0.
- Bytes 0x00,0x01 then 0x18,0xAA,0xBB:
  - drop_cnt=2.
  - out_bytes=0x18AABB.
  - out_bytes holds 0x18AABB through 10 further idle cycles.
- TIMEOUT_CYC=4, bytes 0x08,0x11 then in_valid low for 4 cycles:
  - err pulses once, done never asserts, out_bytes unchanged.
  - Next 0x08,0x01,0x02 gives out_bytes=0x080102.
- TIMEOUT_CYC=4, gap of 3 idle cycles, byte on the 4th cycle:
  - no err.
  - the packet completes normally.
- Two packets back-to-back (0x08,0x01,0x02,0x09,0x03,0x04):
  - done pulses in cycle 4 with 0x080102 and in cycle 7 with 0x090304.
- PKT_BYTES=4, SYNC_BIT=7:
  - 0x80,0x01,0x02,0x03 gives out_bytes=0x80010203.
- Reset asserted mid-packet:
  - outputs return to 0 immediately.
  - drop_cnt saturation at 255 is checked with 300 non-sync bytes.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types, defaults and helpers for the PS/2 packet framer.
package ps2_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } ps2_state_e;

  localparam int DEF_BYTE_W    = 8;
  localparam int DEF_PKT_BYTES = 3;
  localparam int DEF_SYNC_BIT  = 3;

  function automatic int pkt_w(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/ps2_gap_timer.sv
// Inter-byte idle counter; expired is a single-cycle strobe on the idle cycle that reaches the limit.
module ps2_gap_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

      logic [CNT_W-1:0] count_q;
      logic [CNT_W-1:0] count_d;
      logic             hit;

      // The limit is hit on the idle cycle that would make the count equal TIMEOUT_CYC.
      assign hit = run && !clr && (count_q == LAST_CNT);

      always_comb begin
        count_d = count_q;
        if (clr || hit) begin
          count_d = '0;
        end else if (run) begin
          count_d = count_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign expired = hit;
    end else begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, run, clr};
      assign expired       = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ps2_packet_framer.sv
// Assembles fixed-length packets from a strobed byte stream, hunting for a sync bit on byte 0.
module ps2_packet_framer
  import ps2_pkg::*;
#(
  parameter int BYTE_W      = DEF_BYTE_W,
  parameter int PKT_BYTES   = DEF_PKT_BYTES,
  parameter int SYNC_BIT    = DEF_SYNC_BIT,
  parameter int TIMEOUT_CYC = 1000,
  parameter int DROP_W      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BYTE_W-1:0]                 in_byte,
  input  logic                              in_valid,
  output logic [pkt_w(PKT_BYTES,BYTE_W)-1:0] out_bytes,
  output logic                              done,
  output logic                              err,
  output logic [DROP_W-1:0]                 drop_cnt
);

  localparam int PKT_W = pkt_w(PKT_BYTES, BYTE_W);
  localparam int IDX_W = $clog2(PKT_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  ps2_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PKT_W-1:0]  asm_q, asm_d;
  logic [PKT_W-1:0]  out_q, out_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [PKT_W-1:0]  asm_shift;
  logic              gap_run;
  logic              gap_clr;
  logic              gap_expired;

  // Bytes enter at the LSB end so byte 0 ends up in the MSBs once the packet is full.
  assign asm_shift = {asm_q[PKT_W-BYTE_W-1:0], in_byte};

  assign gap_run = (state_q == COLLECT) && !in_valid;
  assign gap_clr = (state_q != COLLECT) || in_valid;

  ps2_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (gap_run),
    .clr    (gap_clr),
    .expired(gap_expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    out_d   = out_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    drop_d  = drop_q;

    case (state_q)
      HUNT: begin
        if (in_valid) begin
          if (in_byte[SYNC_BIT]) begin
            asm_d   = asm_shift;
            idx_d   = IDX_W'(1);
            state_d = COLLECT;
          end else if (drop_q != {DROP_W{1'b1}}) begin
            drop_d = drop_q + DROP_W'(1);
          end
        end
      end

      COLLECT: begin
        if (in_valid) begin
          asm_d = asm_shift;
          if (idx_q == LAST_IDX) begin
            out_d   = asm_shift;
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = HUNT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (gap_expired) begin
          // Partial bytes stay in asm_q but are shifted out by the next packet.
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = HUNT;
        end
      end

      default: begin
        state_d = HUNT;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      idx_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign out_bytes = out_q;
  assign done      = done_q;
  assign err       = err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ps2_packet_framer.sv
// Drives three framer configurations with one shared byte stream and checks them against a packet-level model.
module tb_ps2_packet_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;

  logic [23:0] out3, outd;
  logic [31:0] out4;
  logic        done3, done4, doned;
  logic        err3, err4, errd;
  logic [7:0]  drop3, drop4, dropd;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          n_got;
    logic [31:0] partial;
    int          gap;
    logic [31:0] out;
    bit          done;
    bit          err;
    int          drops;
  } mdl_t;

  mdl_t m3, m4, md;

  always #5 clk = ~clk;

  // 3-byte packets, sync bit 3, short timeout
  ps2_packet_framer #(.BYTE_W(8), .PKT_BYTES(3), .SYNC_BIT(3), .TIMEOUT_CYC(4), .DROP_W(8)) dut3 (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .out_bytes(out3), .done(done3), .err(err3), .drop_cnt(drop3));

  // 4-byte packets, sync bit 7, timeout disabled
  ps2_packet_framer #(.BYTE_W(8), .PKT_BYTES(4), .SYNC_BIT(7), .TIMEOUT_CYC(0), .DROP_W(8)) dut4 (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .out_bytes(out4), .done(done4), .err(err4), .drop_cnt(drop4));

  // all defaults
  ps2_packet_framer dutd (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .out_bytes(outd), .done(doned), .err(errd), .drop_cnt(dropd));

  // One cycle of packet framing described as "bytes collected so far" plus idle-cycle count.
  function automatic mdl_t mdl_step(input mdl_t m, input int nbytes, input int sync, input int tmo,
                                    input logic v, input logic [7:0] b);
    mdl_t r = m;
    r.done = 1'b0;
    r.err  = 1'b0;
    if (v) begin
      if (r.n_got == 0) begin
        if (b[sync]) begin
          r.partial = {24'h0, b};
          r.n_got   = 1;
          r.gap     = 0;
        end else if (r.drops < 255) begin
          r.drops++;
        end
      end else begin
        r.partial = (r.partial << 8) | {24'h0, b};
        r.n_got++;
        r.gap = 0;
        if (r.n_got == nbytes) begin
          r.out   = r.partial;
          r.done  = 1'b1;
          r.n_got = 0;
        end
      end
    end else if (r.n_got > 0 && tmo != 0) begin
      r.gap++;
      if (r.gap == tmo) begin
        r.err   = 1'b1;
        r.n_got = 0;
        r.gap   = 0;
      end
    end
    return r;
  endfunction

  function automatic mdl_t mdl_clear();
    mdl_t r;
    r.n_got = 0; r.partial = '0; r.gap = 0; r.out = '0;
    r.done = 1'b0; r.err = 1'b0; r.drops = 0;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("d3.out",  {40'h0, out3},  {32'h0, m3.out});
    checkOutput("d3.done", {63'h0, done3}, {63'h0, m3.done});
    checkOutput("d3.err",  {63'h0, err3},  {63'h0, m3.err});
    checkOutput("d3.drop", {56'h0, drop3}, 64'(m3.drops));
    checkOutput("d4.out",  {32'h0, out4},  {32'h0, m4.out});
    checkOutput("d4.done", {63'h0, done4}, {63'h0, m4.done});
    checkOutput("d4.err",  {63'h0, err4},  {63'h0, m4.err});
    checkOutput("d4.drop", {56'h0, drop4}, 64'(m4.drops));
    checkOutput("dd.out",  {40'h0, outd},  {32'h0, md.out});
    checkOutput("dd.done", {63'h0, doned}, {63'h0, md.done});
    checkOutput("dd.err",  {63'h0, errd},  {63'h0, md.err});
    checkOutput("dd.drop", {56'h0, dropd}, 64'(md.drops));
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] b);
    @(negedge clk);
    in_valid = v;
    in_byte  = b;
    @(posedge clk);
    m3 = mdl_step(m3, 3, 3, 4, v, b);
    m4 = mdl_step(m4, 4, 7, 0, v, b);
    md = mdl_step(md, 3, 3, 1000, v, b);
    #1;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic sendBytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) applyStimulus(1'b1, bytes[i]);
  endtask

  // Asynchronous reset in the low half of the clock; outputs must clear before any edge.
  task automatic pulseReset();
    @(negedge clk);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    m3 = mdl_clear();
    m4 = mdl_clear();
    md = mdl_clear();
    checkAll();
    @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    m3 = mdl_clear();
    m4 = mdl_clear();
    md = mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    reset = 1'b0;

    sendBytes('{8'h08, 8'h12, 8'h34});
    checkOutput("plan.first", {40'h0, out3}, 64'h081234);
    idle(2);
    sendBytes('{8'h00, 8'h01, 8'h18, 8'hAA, 8'hBB});
    checkOutput("plan.drop2", {56'h0, drop3}, 64'd2);
    idle(10);
    checkOutput("plan.hold", {40'h0, outd}, 64'h18AABB);

    sendBytes('{8'h08, 8'h11});
    idle(4);
    sendBytes('{8'h08, 8'h01, 8'h02});
    checkOutput("plan.after_tmo", {40'h0, out3}, 64'h080102);

    sendBytes('{8'h08, 8'h05});
    idle(3);
    sendBytes('{8'h06});
    checkOutput("plan.gap3", {40'h0, out3}, 64'h080506);

    sendBytes('{8'h08, 8'h01, 8'h02, 8'h09, 8'h03, 8'h04});
    checkOutput("plan.b2b", {40'h0, out3}, 64'h090304);

    sendBytes('{8'h80, 8'h01, 8'h02, 8'h03});
    idle(1);
    checkOutput("plan.pkt4", {32'h0, out4}, 64'h80010203);

    sendBytes('{8'h08, 8'h12});
    pulseReset();
    sendBytes('{8'h34});

    sendBytes('{8'h88});
    idle(1001);

    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'($urandom) & 8'h77);
    checkOutput("plan.sat", {56'h0, drop3}, 64'd255);
    pulseReset();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        idle($urandom_range(1, 8));
      end else begin
        applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom));
      end
      if (i == 900) pulseReset();
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
